// File: rtl/output_argmax_display.sv
// -----------------------------------------------------------------------------
// output_argmax_display
//
// Collects NUM_CLASSES signed output-neuron scores for one inference. The
// scores arrive in class order. The block reports the index of the largest
// score, and ties go to the lowest index. It keeps a 3-digit BCD count of
// completed inferences. A 4-digit multiplexed 7-segment display shows the
// predicted class and that count.
//
// Ports
//   clk, rst_n        : rising-edge clock, asynchronous active-low reset
//   start             : one-cycle request to begin collecting an inference
//   score_valid       : qualifies score; one score accepted per asserted cycle
//   score             : signed Q5.11 score, class 0 first
//   busy              : high while collecting
//   done              : one-cycle pulse when a classification completes
//   class_out         : last predicted class index (held until next result)
//   CA..CG            : active-low segment drives a..g
//   AN                : active-low one-hot digit enables, AN[0] rightmost
//
// Display digits: AN0 = class_out ("-" until the first result after reset),
//                 AN1 = units, AN2 = tens, AN3 = hundreds of the count.
// -----------------------------------------------------------------------------
module output_argmax_display #(
  parameter int SCORE_WIDTH = 16,
  parameter int NUM_CLASSES = 10,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          score_valid,
  input  logic signed [SCORE_WIDTH-1:0] score,
  output logic                          busy,
  output logic                          done,
  output logic [3:0]                    class_out,
  output logic                          CA,
  output logic                          CB,
  output logic                          CC,
  output logic                          CD,
  output logic                          CE,
  output logic                          CF,
  output logic                          CG,
  output logic [3:0]                    AN
);

  localparam int IDX_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
  localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);

  // Active-low {a,b,c,d,e,f,g} patterns
  localparam logic [6:0] SEG_DASH  = 7'b1111110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FINISH  = 2'd2
  } state_t;

  state_t                        state;
  logic [IDX_W-1:0]              idx;
  logic signed [SCORE_WIDTH-1:0] best_score;
  logic [IDX_W-1:0]              best_idx;
  logic                          has_result;
  logic [3:0]                    bcd_units;
  logic [3:0]                    bcd_tens;
  logic [3:0]                    bcd_hundreds;

  logic [REF_W-1:0]              ref_cnt;
  logic [1:0]                    digit_sel;

  // The first score always loads. After that only a strictly greater score
  // replaces the best one, so ties keep the earlier (lower) index.
  logic             take;
  logic [IDX_W-1:0] win_idx;

  assign take    = (idx == '0) || (score > best_score);
  assign win_idx = take ? idx : best_idx;

  // ---------------------------------------------------------------------------
  // Collection FSM and inference counter
  // ---------------------------------------------------------------------------
  // NOTE: every register in a clocked block uses <=. Reads in the same block
  // then see the value from before the edge, and no ordering race can occur.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      idx          <= '0;
      best_score   <= '0;
      best_idx     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      class_out    <= 4'd0;
      has_result   <= 1'b0;
      bcd_units    <= 4'd0;
      bcd_tens     <= 4'd0;
      bcd_hundreds <= 4'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= COLLECT;
            idx        <= '0;
            best_score <= '0;
            best_idx   <= '0;
            busy       <= 1'b1;
          end
        end

        COLLECT: begin
          if (score_valid) begin
            idx <= idx + 1'b1;
            if (take) begin
              best_score <= score;
              best_idx   <= idx;
            end
            if (idx == LAST_IDX) begin
              // The result includes the score accepted on this same edge.
              state      <= FINISH;
              busy       <= 1'b0;
              done       <= 1'b1;
              class_out  <= 4'(win_idx);
              has_result <= 1'b1;
              if (bcd_units == 4'd9) begin
                bcd_units <= 4'd0;
                if (bcd_tens == 4'd9) begin
                  bcd_tens     <= 4'd0;
                  bcd_hundreds <= (bcd_hundreds == 4'd9) ? 4'd0 : bcd_hundreds + 4'd1;
                end else begin
                  bcd_tens <= bcd_tens + 4'd1;
                end
              end else begin
                bcd_units <= bcd_units + 4'd1;
              end
            end
          end
        end

        FINISH: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Display refresh: this counter runs free and is independent of the FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_cnt   <= '0;
      digit_sel <= 2'd0;
    end else if (ref_cnt == REF_LAST) begin
      ref_cnt   <= '0;
      digit_sel <= digit_sel + 2'd1;
    end else begin
      ref_cnt <= ref_cnt + 1'b1;
    end
  end

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b0000001;
      4'd1:    seg_decode = 7'b1001111;
      4'd2:    seg_decode = 7'b0010010;
      4'd3:    seg_decode = 7'b0000110;
      4'd4:    seg_decode = 7'b1001100;
      4'd5:    seg_decode = 7'b0100100;
      4'd6:    seg_decode = 7'b0100000;
      4'd7:    seg_decode = 7'b0001111;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0000100;
      default: seg_decode = SEG_BLANK;
    endcase
  endfunction

  logic [6:0] seg;

  // NOTE: every output of this block gets a default value first. Then no path
  // through the case leaves an output unassigned, so no latch is inferred.
  always_comb begin
    AN  = 4'b1111;
    seg = SEG_BLANK;
    case (digit_sel)
      2'd0: begin
        AN  = 4'b1110;
        seg = has_result ? seg_decode(class_out) : SEG_DASH;
      end
      2'd1: begin
        AN  = 4'b1101;
        seg = seg_decode(bcd_units);
      end
      2'd2: begin
        AN  = 4'b1011;
        seg = seg_decode(bcd_tens);
      end
      default: begin
        AN  = 4'b0111;
        seg = seg_decode(bcd_hundreds);
      end
    endcase
  end

  assign {CA, CB, CC, CD, CE, CF, CG} = seg;

endmodule

// File: tb/tb_output_argmax_display.sv
// -----------------------------------------------------------------------------
// tb_output_argmax_display
//
// Self-checking bench for output_argmax_display with REFRESH_DIV = 4.
// Each inference pushes its expected class and done cycle into a scoreboard.
// A negedge monitor pops the entry on every done pulse and compares it.
// Display contents and rotation are checked by watching AN and the segments.
// -----------------------------------------------------------------------------
module tb_output_argmax_display;

  typedef logic signed [15:0] score_arr_t [10];

  typedef struct {
    int     cls;
    longint due;
  } exp_t;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic               score_valid;
  logic signed [15:0] score;
  logic               busy;
  logic               done;
  logic [3:0]         class_out;
  logic               ca, cb, cc, cd, ce, cf, cg;
  logic [3:0]         an;

  int     tests;
  int     fails;
  longint cyc;
  exp_t   sb[$];
  logic   prev_done;
  int     exp_count;
  int     last_cls;

  output_argmax_display #(
    .SCORE_WIDTH(16),
    .NUM_CLASSES(10),
    .REFRESH_DIV(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .score_valid(score_valid),
    .score      (score),
    .busy       (busy),
    .done       (done),
    .class_out  (class_out),
    .CA         (ca),
    .CB         (cb),
    .CC         (cc),
    .CD         (cd),
    .CE         (ce),
    .CF         (cf),
    .CG         (cg),
    .AN         (an)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0:       seg_of = 7'b0000001;
      1:       seg_of = 7'b1001111;
      2:       seg_of = 7'b0010010;
      3:       seg_of = 7'b0000110;
      4:       seg_of = 7'b1001100;
      5:       seg_of = 7'b0100100;
      6:       seg_of = 7'b0100000;
      7:       seg_of = 7'b0001111;
      8:       seg_of = 7'b0000000;
      9:       seg_of = 7'b0000100;
      default: seg_of = 7'b1111111;
    endcase
  endfunction

  // Scoreboard monitor: every done pulse must match a pushed expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      tests++;
      if (prev_done) begin
        fails++;
        $display("FAIL done_width: done high two cycles in a row at cycle %0d", cyc);
      end
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_done: done at cycle %0d with no inference pending", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        tests++;
        if (class_out !== 4'(e.cls)) begin
          fails++;
          $display("FAIL class_out: got %0d expected %0d", class_out, e.cls);
        end
        tests++;
        if (cyc !== e.due) begin
          fails++;
          $display("FAIL done_latency: done at cycle %0d expected %0d", cyc, e.due);
        end
        tests++;
        if (busy !== 1'b0) begin
          fails++;
          $display("FAIL busy_at_done: got %b expected 0", busy);
        end
      end
    end
    prev_done = done;
  end

  // Runs one inference. stall inserts a score_valid=0 cycle before each score.
  // start_mid pulses start while the 4th score is presented.
  task automatic run_inference(input score_arr_t sc, input bit stall, input bit start_mid);
    logic signed [15:0] best;
    int bi;
    exp_t e;
    best = sc[0];
    bi   = 0;
    for (int i = 1; i < 10; i++) begin
      if (sc[i] > best) begin
        best = sc[i];
        bi   = i;
      end
    end
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL busy_after_start: got %b expected 1", busy);
    end
    for (int i = 0; i < 10; i++) begin
      if (stall) begin
        score_valid = 1'b0;
        score       = 16'($urandom);
        @(negedge clk);
        tests++;
        if (busy !== 1'b1) begin
          fails++;
          $display("FAIL busy_stall: got %b expected 1 at score %0d", busy, i);
        end
      end
      score_valid = 1'b1;
      score       = sc[i];
      start       = start_mid && (i == 3);
      if (i == 9) begin
        e.cls = bi;
        e.due = cyc + 1;
        sb.push_back(e);
      end
      @(negedge clk);
      if (i < 9) begin
        tests++;
        if (busy !== 1'b1) begin
          fails++;
          $display("FAIL busy_collect: got %b expected 1 after score %0d", busy, i);
        end
      end
    end
    score_valid = 1'b0;
    start       = 1'b0;
    @(negedge clk);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL missing_done: %0d result(s) still pending", sb.size());
      sb.delete();
    end
    exp_count = (exp_count + 1) % 1000;
    last_cls  = bi;
  endtask

  // Watches 20 cycles of refresh. AN must rotate 0->1->2->3 with a dwell of
  // 4 cycles, and each digit must show its expected pattern.
  task automatic check_display(input bit dash, input int cls, input int cnt);
    logic [6:0] exp_seg [4];
    logic [6:0] got;
    int k, prev_k, run;
    exp_seg[0] = dash ? 7'b1111110 : seg_of(cls);
    exp_seg[1] = seg_of(cnt % 10);
    exp_seg[2] = seg_of((cnt / 10) % 10);
    exp_seg[3] = seg_of(cnt / 100);
    prev_k = -1;
    run    = 0;
    for (int s = 0; s < 20; s++) begin
      @(negedge clk);
      got = {ca, cb, cc, cd, ce, cf, cg};
      case (an)
        4'b1110: k = 0;
        4'b1101: k = 1;
        4'b1011: k = 2;
        4'b0111: k = 3;
        default: k = -1;
      endcase
      tests++;
      if (k < 0) begin
        fails++;
        $display("FAIL an_onehot: got %b expected one active-low digit", an);
        continue;
      end
      tests++;
      if (got !== exp_seg[k]) begin
        fails++;
        $display("FAIL seg_digit%0d: got %b expected %b", k, got, exp_seg[k]);
      end
      if (prev_k >= 0 && k != prev_k) begin
        tests++;
        if (k != (prev_k + 1) % 4) begin
          fails++;
          $display("FAIL an_order: got digit %0d after %0d", k, prev_k);
        end
        if (run_valid(prev_k, s, run)) begin
          tests++;
          if (run != 4) begin
            fails++;
            $display("FAIL an_dwell: digit %0d held %0d cycles expected 4", prev_k, run);
          end
        end
        run = 1;
      end else begin
        run++;
      end
      prev_k = k;
    end
  endtask

  // The first run seen may be partial. Only runs that started inside the
  // window are complete.
  function automatic bit run_valid(input int prev_k, input int s, input int run);
    return (prev_k >= 0) && (s - run > 0);
  endfunction

  task automatic test_reset();
    rst_n       = 1'b0;
    start       = 1'b0;
    score_valid = 1'b0;
    score       = '0;
    #3;
    tests++;
    if ({busy, done, class_out} !== 6'b0) begin
      fails++;
      $display("FAIL reset_outputs: busy/done/class got %b expected 000000", {busy, done, class_out});
    end
    tests++;
    if (an !== 4'b1110) begin
      fails++;
      $display("FAIL reset_an: got %b expected 1110", an);
    end
    tests++;
    if ({ca, cb, cc, cd, ce, cf, cg} !== 7'b1111110) begin
      fails++;
      $display("FAIL reset_seg: got %b expected 1111110", {ca, cb, cc, cd, ce, cf, cg});
    end
    @(negedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    exp_count = 0;
    check_display(1'b1, 0, 0);
  endtask

  task automatic test_basic();
    score_arr_t sc;
    sc = '{-16'sd3, 16'sd5, 16'sd2, 16'sd9, 16'sd1, 16'sd9, 16'sd0, -16'sd8, 16'sd4, 16'sd7};
    run_inference(sc, 1'b0, 1'b0);
    check_display(1'b0, 3, 1);
  endtask

  task automatic test_all_min();
    score_arr_t sc;
    for (int i = 0; i < 10; i++) sc[i] = -16'sd32768;
    run_inference(sc, 1'b0, 1'b0);
    check_display(1'b0, 0, 2);
  endtask

  task automatic test_stall();
    score_arr_t sc;
    sc = '{-16'sd3, 16'sd5, 16'sd2, 16'sd9, 16'sd1, 16'sd9, 16'sd0, -16'sd8, 16'sd4, 16'sd7};
    run_inference(sc, 1'b1, 1'b0);
    check_display(1'b0, 3, 3);
  endtask

  task automatic test_ignore();
    score_arr_t sc;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      score_valid = 1'b1;
      score       = 16'sd1000;
      @(negedge clk);
      score_valid = 1'b0;
      tests++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        fails++;
        $display("FAIL idle_valid: busy=%b done=%b expected 0 0", busy, done);
      end
    end
    sc = '{16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd5, 16'sd6, 16'sd100, -16'sd5, 16'sd100, 16'sd0};
    run_inference(sc, 1'b0, 1'b1);
    check_display(1'b0, 6, 4);
  endtask

  task automatic test_abort();
    score_arr_t sc;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      score_valid = 1'b1;
      score       = 16'(i * 3);
      @(negedge clk);
    end
    score_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({busy, done, class_out} !== 6'b0) begin
      fails++;
      $display("FAIL abort_outputs: busy/done/class got %b expected 000000", {busy, done, class_out});
    end
    tests++;
    if (an !== 4'b1110 || {ca, cb, cc, cd, ce, cf, cg} !== 7'b1111110) begin
      fails++;
      $display("FAIL abort_display: an=%b seg=%b expected 1110 1111110", an, {ca, cb, cc, cd, ce, cf, cg});
    end
    @(negedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    exp_count = 0;
    check_display(1'b1, 0, 0);
    for (int i = 0; i < 10; i++) sc[i] = 16'sd0;
    sc[8] = 16'sd50;
    sc[9] = -16'sd1;
    run_inference(sc, 1'b0, 1'b0);
    check_display(1'b0, 8, 1);
  endtask

  task automatic test_wrap();
    score_arr_t sc;
    while (exp_count != 999) begin
      for (int i = 0; i < 10; i++) sc[i] = 16'($urandom_range(0, 15)) - 16'sd8;
      run_inference(sc, 1'b0, 1'b0);
    end
    check_display(1'b0, last_cls, 999);
    for (int i = 0; i < 10; i++) sc[i] = 16'($urandom_range(0, 15)) - 16'sd8;
    run_inference(sc, 1'b0, 1'b0);
    check_display(1'b0, last_cls, 0);
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    cyc       = 0;
    prev_done = 1'b0;
    exp_count = 0;
    last_cls  = 0;
    test_reset();
    test_basic();
    test_all_min();
    test_stall();
    test_ignore();
    test_abort();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/output_argmax_display.md
OUTPUT_ARGMAX_DISPLAY -- requirements
Module: output_argmax_display

Interface
REQ-001 SHALL have parameter SCORE_WIDTH, default 16, meaning the signed fixed-point width of one output-neuron score (Q5.11).
REQ-002 SHALL have parameter NUM_CLASSES, default 10, meaning the number of output-layer scores per inference.
REQ-003 SHALL have parameter REFRESH_DIV, default 100000, meaning the clk cycles each display digit stays enabled.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, the reset: asynchronous, active-low.
REQ-006 SHALL have port start, input, 1, a one-cycle request to begin collecting one inference's scores.
REQ-007 SHALL have port score_valid, input, 1, a qualifier for score; one score is accepted per asserted cycle.
REQ-008 SHALL have port score, input, SCORE_WIDTH, a signed output-neuron score, presented in class order 0..NUM_CLASSES-1.
REQ-009 SHALL have port busy, output, 1, asserted while collecting.
REQ-010 SHALL have port done, output, 1, a one-cycle pulse when a classification completes.
REQ-011 SHALL have port class_out, output, 4, the last predicted class index.
REQ-012 SHALL have ports CA, CB, CC, CD, CE, CF, CG, each output, 1, the active-low segment drives a..g.
REQ-013 SHALL have port AN, output, 4, the active-low one-hot digit enables; AN[0] is the rightmost digit.

Function
REQ-014 SHALL implement FSM states IDLE, COLLECT and FINISH.
REQ-015 In IDLE, start=1 SHALL move the FSM to COLLECT, clear the index counter and the best-score register, and set busy=1 from the next cycle.
REQ-016 In IDLE, score_valid SHALL be ignored.
REQ-017 In COLLECT, start SHALL be ignored; busy SHALL stay 1.
REQ-018 In COLLECT, each score_valid=1 cycle SHALL:
  - increment the index counter;
  - load best_score/best_idx when index==0 or score > best_score (signed, strict).
REQ-019 Ties SHALL keep the lowest index.
REQ-020 Cycles with score_valid=0 in COLLECT SHALL be stalls with no state change.
REQ-021 The cycle after the NUM_CLASSES-th accepted score, the FSM SHALL be in FINISH, with:
  - done=1;
  - class_out=best_idx;
  - busy=0;
  - the inference counter incremented.
  It SHALL return to IDLE on the following cycle.
REQ-022 done SHALL be high for exactly one cycle per completed inference.
REQ-023 class_out SHALL hold its value until the next FINISH.
REQ-024 The inference counter SHALL be 3-digit BCD (units, tens, hundreds) and wrap 999 -> 000.
REQ-025 A refresh counter SHALL count 0..REFRESH_DIV-1 continuously. At wrap, the active digit SHALL advance AN0 -> AN1 -> AN2 -> AN3 -> AN0.
REQ-026 Digit sources SHALL be:
  - AN0: class_out;
  - AN1: units;
  - AN2: tens;
  - AN3: hundreds.
REQ-027 Before the first completed inference since reset, AN0 SHALL show "-" (only CG=0).
REQ-028 Segment encoding SHALL be standard 0-9, active low, as {CA..CG}:
  - 0 = 0000001;
  - 1 = 1001111;
  - 7 = 0001111;
  - 8 = 0000000.
REQ-029 Digit display SHALL be independent of FSM state and SHALL NOT stall.

Reset
REQ-030 rst_n=0 SHALL immediately force:
  - FSM=IDLE, busy=0, done=0, class_out=0;
  - index, best registers, BCD counter and refresh counter = 0;
  - AN=1110, {CA..CG}=1111110 ("-").
REQ-031 Reset asserted mid-COLLECT SHALL abort without a done pulse or counter increment.

Verification
REQ-032 With REFRESH_DIV=4, reset, then start, then scores [-3,5,2,9,1,9,0,-8,4,7] on consecutive cycles -> done one cycle after the 10th score, class_out=3 (tie at index 5 loses), counter=001.
REQ-033 With all ten scores = -32768 -> class_out=0, done pulses once.
REQ-034 With the same scores but score_valid low on alternate cycles -> same class_out, done 1 cycle after the 10th valid score, busy high throughout.
REQ-035 With start pulsed during COLLECT and score_valid pulsed in IDLE -> no effect on result or counter.
REQ-036 rst_n low after 5 scores -> immediate AN=1110 and "-", no done; restart with a max at index 8 -> class_out=8, counter=001.
REQ-037 With 1000 inferences -> counter wraps to 000; AN rotates every 4 cycles; AN1/AN2/AN3 segments match BCD digits.
